imem_arbiter: RTL
=================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameters SHALL be declared one per line as name, default, meaning:
- NUM_CORES, 8, number of requesting cores
- ADDR_W, 16, instruction address width
- DATA_W, 16, instruction word width
- MEM_LATENCY, 1, cycles from mem_read to valid mem_data_out (1..4)
REQ-002 Ports SHALL be declared one per line as name, direction, width, meaning:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- core_req  input  NUM_CORES  per-core fetch request, level
- core_addr  input  NUM_CORES*ADDR_W  packed addresses; core i at bits [i*ADDR_W +: ADDR_W]
- core_gnt  output  NUM_CORES  one-hot, one-cycle pulse when the core's request issues to memory
- core_rvalid  output  NUM_CORES  one-hot, one-cycle pulse when core_rdata holds that core's word
- core_rdata  output  DATA_W  shared returned instruction word
- mem_read  output  1  read strobe to instruction memory
- mem_address  output  ADDR_W  address to instruction memory
- mem_data_out  input  DATA_W  read data from instruction memory

Function
REQ-003 FSM SHALL have states IDLE, ISSUE, WAIT, RESP; transitions: IDLE->ISSUE when any core_req bit is high, otherwise stay; ISSUE->WAIT always; WAIT->RESP after MEM_LATENCY cycles in WAIT; RESP->IDLE always.
REQ-004 In IDLE, the winner SHALL be chosen round-robin: first asserted core_req index searching upward from last_grant+1, wrapping from NUM_CORES-1 to 0; winner index and its address are registered on the IDLE->ISSUE edge.
REQ-005 last_grant SHALL update to the winner index on the IDLE->ISSUE edge.
REQ-006 In ISSUE only: mem_read=1, mem_address=registered address, core_gnt[winner]=1; in all other states mem_read=0 and core_gnt=0.
REQ-007 mem_data_out SHALL be registered into core_rdata on the final WAIT cycle's closing edge; core_rdata SHALL hold its value until the next capture.
REQ-008 In RESP only, core_rvalid[winner]=1; otherwise core_rvalid=0.
REQ-009 Latency: core_req sampled in IDLE at cycle t -> core_gnt at t+1 -> core_rvalid at t+2+MEM_LATENCY; one transaction is outstanding at most.
REQ-010 Handshake: a core SHALL hold core_req and core_addr stable until its core_rvalid; core_req still high in the cycle after RESP counts as a new request.
REQ-011 A core_req bit deasserted before selection in IDLE SHALL be ignored; core_req/core_addr changes after selection SHALL NOT affect the transaction in flight.
REQ-012 With all NUM_CORES requesting continuously, each core SHALL be granted exactly once per NUM_CORES transactions (no starvation).

Reset
REQ-013 On rst=1, regardless of clock: state=IDLE, last_grant=NUM_CORES-1 (so core 0 wins first), core_gnt=0, core_rvalid=0, core_rdata=0, mem_read=0, mem_address=0.
REQ-014 Reset asserted mid-transaction SHALL discard it; no core_rvalid is produced for it after release.
REQ-015 First arbitration SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-016 Macro IMEM_ARB_STATS_EN: when defined, add output grant_count (16 bits, reset 0), incremented on each IDLE->ISSUE edge and saturating at 16'hFFFF; when undefined, the port and counter do not exist and all other behaviour is identical.

Verification
REQ-017 Single request: core 3 req, addr 16'd12 with MEM_LATENCY=1 -> core_gnt=8'b0000_1000 with mem_address=12 and mem_read=1 one cycle later; core_rvalid[3] exactly 3 cycles after sample; core_rdata = memory word at 12.
REQ-018 Round-robin: all 8 cores request continuously after reset -> grant order 0,1,...,7,0; each core_rvalid matches its own address data.
REQ-019 Wrap and skip: last_grant=6, requests from cores 2 and 7 -> core 7 granted, then core 2.
REQ-020 Request withdrawn: core 5 raises req for 0 cycles in IDLE (drops before sampling edge) -> no gnt, mem_read stays 0.
REQ-021 Reset in WAIT: assert rst during WAIT -> all outputs 0 immediately; no core_rvalid after release; next request from core 0 granted first.
REQ-022 With IMEM_ARB_STATS_EN: 10 completed transactions -> grant_count=10; reset -> 0.

Source files
------------

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Round-robin instruction-memory arbiter. Serves one core fetch
//               at a time and returns the word on a shared bus with a
//               per-core valid pulse. Optional grant counter: IMEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
    parameter int NUM_CORES   = 8,   // number of requesting cores
    parameter int ADDR_W      = 16,  // instruction address width
    parameter int DATA_W      = 16,  // instruction word width
    parameter int MEM_LATENCY = 1    // cycles from mem_read to valid mem_data_out (1..4)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_read,
    output logic [ADDR_W-1:0]           mem_address,
    input  logic [DATA_W-1:0]           mem_data_out
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [15:0]                 grant_count
`endif
);

    localparam int c_IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int c_CNT_W = 3;
    localparam logic [c_CNT_W-1:0] c_LAST_WAIT = c_CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_IDX_W-1:0]   r_last_grant;
    logic [c_IDX_W-1:0]   r_winner;
    logic [ADDR_W-1:0]    r_addr;
    logic [c_CNT_W-1:0]   r_wait_cnt;
    logic [DATA_W-1:0]    r_rdata;
    logic [c_IDX_W-1:0]   w_sel;
    logic                 w_sel_valid;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [NUM_CORES-1:0] w_winner_onehot;
    logic                 w_take;
    int                   w_pos;

    // First requester strictly after last_grant, wrapping to index 0.
    always_comb begin
        w_sel       = '0;
        w_sel_valid = 1'b0;
        w_pos       = 0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            w_pos = int'(r_last_grant) + k;
            if (w_pos >= NUM_CORES) begin
                w_pos = w_pos - NUM_CORES;
            end
            if (!w_sel_valid && core_req[c_IDX_W'(w_pos)]) begin
                w_sel       = c_IDX_W'(w_pos);
                w_sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_addr      = '0;
        w_winner_onehot = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_sel == c_IDX_W'(i)) begin
                w_sel_addr = core_addr[i*ADDR_W +: ADDR_W];
            end
            w_winner_onehot[i] = (r_winner == c_IDX_W'(i));
        end
    end

    assign w_take = (r_state == IDLE) && w_sel_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        core_gnt     = '0;
        core_rvalid  = '0;
        mem_read     = 1'b0;
        mem_address  = '0;
        case (r_state)
            IDLE: begin
                if (w_sel_valid) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_next_state = WAIT;
                mem_read     = 1'b1;
                mem_address  = r_addr;
                core_gnt     = w_winner_onehot;
            end
            WAIT: begin
                if (r_wait_cnt == c_LAST_WAIT) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
                core_rvalid  = w_winner_onehot;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Winner and address are frozen at selection so later input changes cannot disturb the fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= c_IDX_W'(NUM_CORES - 1);
            r_winner     <= '0;
            r_addr       <= '0;
            r_wait_cnt   <= '0;
            r_rdata      <= '0;
        end else begin
            if (w_take) begin
                r_last_grant <= w_sel;
                r_winner     <= w_sel;
                r_addr       <= w_sel_addr;
            end
            if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if ((r_state == WAIT) && (r_wait_cnt == c_LAST_WAIT)) begin
                r_rdata <= mem_data_out;
            end
        end
    end

    assign core_rdata = r_rdata;

`ifdef IMEM_ARB_STATS_EN
    logic [15:0] r_grant_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_count <= '0;
        end else if (w_take && (r_grant_count != 16'hFFFF)) begin
            r_grant_count <= r_grant_count + 16'd1;
        end
    end

    assign grant_count = r_grant_count;
`endif

endmodule
`default_nettype wire
